// File: rtl/btn_cond_pkg.sv
// Shared types and helpers for the push-button conditioner.
// Optional feature macro used by the cells: BTN_COND_AUTO_REPEAT_EN.
package btn_cond_pkg;

  // Per-button press/hold state; REPEATING only reachable with auto-repeat built in.
  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    HOLD      = 2'd1,
    REPEATING = 2'd2
  } btn_state_e;

  // Bits needed for a counter that must hold values 0..max.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_cell.sv
// One button: two-flop synchroniser, debounce filter and press/release/repeat FSM.
// Input raw_pressed is already normalised (1 = pressed).
// Auto-repeat (HOLD -> REPEATING pulses) is built only with BTN_COND_AUTO_REPEAT_EN.
// Handshake: none; every output is a free-running registered level or 1-cycle pulse,
// valid on every clock with no ready/back-pressure.
module btn_debounce_cell
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int HOLD_CYC     = 25000000,
  parameter int REPEAT_CYC   = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_pressed,
  output logic       level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output btn_state_e state_dbg
);

  localparam int DB_W = cnt_w(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic            sync_meta;
  logic            sync_q;
  logic [DB_W-1:0] db_cnt;
  logic            db_flip;
  logic            level_rise;
  logic            level_fall;

  btn_state_e state;
  btn_state_e state_next;
  logic       press_next;
  logic       release_next;

  // Two-flop synchroniser; reset loads the released value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= raw_pressed;
      sync_q    <= sync_meta;
    end
  end

  // The level flips on the edge where the disagreement has lasted DEBOUNCE_CYC cycles.
  assign db_flip    = (sync_q != level) && (db_cnt == DB_LAST);
  assign level_rise = db_flip && sync_q;
  assign level_fall = db_flip && !sync_q;

  // Debounce counter and filtered level; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt <= '0;
      level  <= 1'b0;
    end else if (sync_q == level) begin
      db_cnt <= '0;
    end else if (db_flip) begin
      db_cnt <= '0;
      level  <= sync_q;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign state_dbg = state;

`ifdef BTN_COND_AUTO_REPEAT_EN
  localparam int RP_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int RP_W   = cnt_w(RP_MAX);
  localparam logic [RP_W-1:0] HOLD_LAST   = RP_W'(HOLD_CYC - 1);
  localparam logic [RP_W-1:0] REPEAT_LAST = RP_W'(REPEAT_CYC - 1);

  logic [RP_W-1:0] rp_cnt;
  logic [RP_W-1:0] rp_cnt_next;
  logic            repeat_next;

  // Next state and pulses; a release on the cycle a repeat is due suppresses the repeat.
  always_comb begin
    state_next   = state;
    rp_cnt_next  = rp_cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    repeat_next  = 1'b0;
    case (state)
      RELEASED: begin
        if (level_rise) begin
          state_next  = HOLD;
          press_next  = 1'b1;
          rp_cnt_next = '0;
        end
      end
      HOLD: begin
        if (level_fall) begin
          state_next   = RELEASED;
          release_next = 1'b1;
          rp_cnt_next  = '0;
        end else if (rp_cnt == HOLD_LAST) begin
          state_next  = REPEATING;
          repeat_next = 1'b1;
          rp_cnt_next = '0;
        end else begin
          rp_cnt_next = rp_cnt + 1'b1;
        end
      end
      REPEATING: begin
        if (level_fall) begin
          state_next   = RELEASED;
          release_next = 1'b1;
          rp_cnt_next  = '0;
        end else if (rp_cnt == REPEAT_LAST) begin
          repeat_next = 1'b1;
          rp_cnt_next = '0;
        end else begin
          rp_cnt_next = rp_cnt + 1'b1;
        end
      end
      default: begin
        state_next  = RELEASED;
        rp_cnt_next = '0;
      end
    endcase
  end

  // State, repeat counter and registered pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RELEASED;
      rp_cnt        <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state         <= state_next;
      rp_cnt        <= rp_cnt_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      repeat_pulse  <= repeat_next;
    end
  end
`else
  // Next state and pulses without auto-repeat: HOLD lasts until release.
  always_comb begin
    state_next   = state;
    press_next   = 1'b0;
    release_next = 1'b0;
    case (state)
      RELEASED: begin
        if (level_rise) begin
          state_next = HOLD;
          press_next = 1'b1;
        end
      end
      HOLD: begin
        if (level_fall) begin
          state_next   = RELEASED;
          release_next = 1'b1;
        end
      end
      default: state_next = RELEASED;
    endcase
  end

  // State and registered press/release pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RELEASED;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
    end
  end

  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN raw button pins: polarity normalisation, then one independent
// sync/debounce/FSM cell per button. btn_level feeds the PIO button inputs.
// Optional feature macro: BTN_COND_AUTO_REPEAT_EN (builds the auto-repeat pulses).
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int HOLD_CYC     = 25000000,
  parameter int REPEAT_CYC   = 5000000
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  logic [N_BTN-1:0] raw_pressed;
  // Per-button FSM state, kept for hierarchical probing only.
  btn_state_e       dbg_state_unused [N_BTN];

  // Normalise so that 1 always means pressed inside the cells.
  assign raw_pressed = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  for (genvar i = 0; i < N_BTN; i++) begin : g_cell
    btn_debounce_cell #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .HOLD_CYC    (HOLD_CYC),
      .REPEAT_CYC  (REPEAT_CYC)
    ) u_cell (
      .clk          (clk_clk),
      .reset        (reset_reset),
      .raw_pressed  (raw_pressed[i]),
      .level        (btn_level[i]),
      .press_pulse  (btn_press[i]),
      .release_pulse(btn_release[i]),
      .repeat_pulse (btn_repeat[i]),
      .state_dbg    (dbg_state_unused[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (DEBOUNCE_CYC=4, HOLD_CYC=10, REPEAT_CYC=3,
// ACTIVE_LOW=1). Expected pulse events are pushed with their due cycle when the
// stimulus is driven; a negedge monitor pops them and checks every output each cycle.
module tb_btn_conditioner;

  localparam int N      = 4;
  localparam int DB     = 4;
  localparam int HOLD   = 10;
  localparam int REP    = 3;
  localparam int LAT    = DB + 2;  // raw change driven after edge t -> level flips at edge t+LAT
  localparam int W      = 36;      // {cycle[31:0], btn[1:0], kind[1:0]}

  localparam logic [1:0] K_PRESS  = 2'd0;
  localparam logic [1:0] K_REL    = 2'd1;
  localparam logic [1:0] K_REPEAT = 2'd2;
  localparam logic [1:0] K_RESET  = 2'd3;

`ifdef BTN_COND_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_repeat;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] keep_q[$];
  logic [N-1:0] exp_level = '0;
  logic [N-1:0] exp_press;
  logic [N-1:0] exp_rel;
  logic [N-1:0] exp_rep;
  logic [W-1:0] ent;

  btn_conditioner #(
    .N_BTN       (N),
    .ACTIVE_LOW  (1),
    .DEBOUNCE_CYC(DB),
    .HOLD_CYC    (HOLD),
    .REPEAT_CYC  (REP)
  ) dut (
    .clk_clk    (clk),
    .reset_reset(reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  // Clock and edge counter: after posedge k, cyc == k.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: apply events due this cycle, then check all four outputs.
  always @(negedge clk) begin
    exp_press = '0;
    exp_rel   = '0;
    exp_rep   = '0;
    keep_q    = {};
    foreach (exp_q[i]) begin
      ent = exp_q[i];
      if (int'(ent[35:4]) == cyc) begin
        case (ent[1:0])
          K_PRESS:  begin exp_press[ent[3:2]] = 1'b1; exp_level[ent[3:2]] = 1'b1; end
          K_REL:    begin exp_rel[ent[3:2]]   = 1'b1; exp_level[ent[3:2]] = 1'b0; end
          K_REPEAT: exp_rep[ent[3:2]] = 1'b1;
          default:  exp_level = '0;
        endcase
      end else begin
        keep_q.push_back(ent);
      end
    end
    exp_q = keep_q;

    total++;
    assert (btn_level === exp_level) else begin
      bad++;
      $error("FAIL level cyc=%0d got=%h exp=%h", cyc, btn_level, exp_level);
    end
    total++;
    assert (btn_press === exp_press) else begin
      bad++;
      $error("FAIL press cyc=%0d got=%h exp=%h", cyc, btn_press, exp_press);
    end
    total++;
    assert (btn_release === exp_rel) else begin
      bad++;
      $error("FAIL release cyc=%0d got=%h exp=%h", cyc, btn_release, exp_rel);
    end
    total++;
    assert (btn_repeat === exp_rep) else begin
      bad++;
      $error("FAIL repeat cyc=%0d got=%h exp=%h", cyc, btn_repeat, exp_rep);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int b, input logic [1:0] k);
    exp_q.push_back({32'(c), 2'(b), k});
  endtask

  // Press button b, hold raw low for hold_len cycles past the press pulse, release.
  // Repeats are expected only while strictly before the release cycle.
  task automatic hold_btn(input int b, input int hold_len);
    int p;
    int r;
    p = cyc + LAT;
    r = p + hold_len + LAT;
    push(p, b, K_PRESS);
    if (REP_EN) begin
      for (int k = 0; p + HOLD + k * REP < r; k++) push(p + HOLD + k * REP, b, K_REPEAT);
    end
    push(r, b, K_REL);
    btn_raw[b] = 1'b0;
    step(LAT + hold_len);
    btn_raw[b] = 1'b1;
    step(LAT + 4);
  endtask

  initial begin
    int glen;
    int t;
    reset   = 1'b1;
    btn_raw = '1;
    step(3);
    reset = 1'b0;
    step(2);

    // Single short press on button 0: press/level at +6, one-cycle pulse.
    hold_btn(0, 2);

    // Glitch shorter than the debounce window on button 1: nothing reported.
    glen = $urandom_range(1, DB - 1);
    btn_raw[1] = 1'b0;
    step(glen);
    btn_raw[1] = 1'b1;
    step(10);

    // Long hold on button 2: repeats at +10,+13,+16,+19,+22, release after.
    hold_btn(2, 18);

    // Release lands on the cycle a repeat is due (+25): release only.
    hold_btn(3, 19);

    // Longer hold on button 1.
    hold_btn(1, 30);

    // All four pressed on one edge, reset mid-hold, reset released while held.
    t = cyc;
    for (int b = 0; b < N; b++) push(t + LAT, b, K_PRESS);
    btn_raw = '0;
    step(LAT + 2);
    push(t + LAT + 3, 0, K_RESET);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    t = cyc;
    for (int b = 0; b < N; b++) push(t + LAT, b, K_PRESS);
    step(LAT);
    for (int b = 0; b < N; b++) push(t + 2 * LAT, b, K_REL);
    btn_raw = '1;
    step(LAT + 5);

    total++;
    assert (exp_q.size() === 0) else begin
      bad++;
      $error("FAIL leftover_events got=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
